instruction_cache: RTL and testbench

// - Fetch-side initiator for the instruction memory. Turns the pipeline's 32-bit PC into 128-bit block reads
//   (MEM_READ/MEM_ADDRESS/MEM_READINST/MEM_BUSYWAIT) and returns one 32-bit instruction per cycle on a hit.
// - Direct-mapped, 8 blocks x 16 bytes. Sits between the IF stage / PC register and the block-wide instruction memory.
// - Stalls the pipeline through BUSYWAIT while a block refill is in progress.

---
 rtl/rv32_fetch_pkg.sv | 23 ++
 rtl/icache_data_array.sv | 36 +++
 rtl/instruction_cache.sv | 70 +++++++
 tb/tb_instruction_cache.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/rv32_fetch_pkg.sv
// Shared fetch-side constants and types for the direct-mapped instruction cache.
package rv32_fetch_pkg;
   localparam int IDX_BITS   = 3;
   localparam int NUM_BLOCKS = 1 << IDX_BITS;
   localparam int MEM_ADDR_W = 6;
   localparam int TAG_BITS   = MEM_ADDR_W - IDX_BITS;
   localparam int BLOCK_W    = 128;
   localparam int OFF_BITS   = 2;

   // Field positions within the byte-address PC
   localparam int OFF_LSB = 2;
   localparam int IDX_LSB = 4;
   localparam int TAG_LSB = 7;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {IDLE, FETCH, UPDATE} fetch_state_t;

   function automatic logic [31:0] get_word(input logic [BLOCK_W-1:0] blk,
                                            input logic [OFF_BITS-1:0] off);
      return blk[off*32 +: 32];
   endfunction
endpackage

// File: rtl/icache_data_array.sv
// Block storage for the instruction cache: async read, sync write, async clear of valid bits.
module icache_data_array
   import rv32_fetch_pkg::*;
(
   input  logic                CLK,
   input  logic                RESET,
   input  logic [IDX_BITS-1:0] rd_idx,
   output logic [BLOCK_W-1:0]  rd_block,
   output logic [TAG_BITS-1:0] rd_tag,
   output logic                rd_valid,
   input  logic                wr_en,
   input  logic [IDX_BITS-1:0] wr_idx,
   input  logic [TAG_BITS-1:0] wr_tag,
   input  logic [BLOCK_W-1:0]  wr_block
);
   logic [BLOCK_W-1:0]  data_q [NUM_BLOCKS];
   logic [TAG_BITS-1:0] tag_q  [NUM_BLOCKS];
   logic [NUM_BLOCKS-1:0] valid_q;

   // Tags and data are left uninitialised; only valid bits gate a hit
   always_ff @(posedge CLK) begin
      if (wr_en) begin
         data_q[wr_idx] <= wr_block;
         tag_q[wr_idx]  <= wr_tag;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)     valid_q         <= '0;
      else if (wr_en) valid_q[wr_idx] <= 1'b1;
   end

   assign rd_block = data_q[rd_idx];
   assign rd_tag   = tag_q[rd_idx];
   assign rd_valid = valid_q[rd_idx];
endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped 8 x 16-byte instruction cache with zero-latency hits and a
// blocking single-block refill from the instruction memory.
module instruction_cache
   import rv32_fetch_pkg::*;
(
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [31:0]           PC,
   output logic [31:0]           INSTRUCTION,
   output logic                  BUSYWAIT,
   output logic                  MEM_READ,
   output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
   input  logic [BLOCK_W-1:0]    MEM_READINST,
   input  logic                  MEM_BUSYWAIT
);
   fetch_state_t state;
   logic [BLOCK_W-1:0]  refill_q;
   logic [BLOCK_W-1:0]  rd_block;
   logic [TAG_BITS-1:0] rd_tag;
   logic                rd_valid;
   logic                hit;
   logic                pc_unused;

   assign pc_unused = ^{PC[31:10], PC[1:0]};

   icache_data_array u_array (
      .CLK      (CLK),
      .RESET    (RESET),
      .rd_idx   (PC[IDX_LSB +: IDX_BITS]),
      .rd_block (rd_block),
      .rd_tag   (rd_tag),
      .rd_valid (rd_valid),
      .wr_en    (state == UPDATE),
      .wr_idx   (MEM_ADDRESS[IDX_BITS-1:0]),
      .wr_tag   (MEM_ADDRESS[MEM_ADDR_W-1:IDX_BITS]),
      .wr_block (refill_q)
   );

   assign hit = rd_valid && (rd_tag == PC[TAG_LSB +: TAG_BITS]);

   // RESET gating keeps the pipeline unstalled and fed NOPs while reset is held
   assign BUSYWAIT    = RESET && !((state == IDLE) && hit);
   assign INSTRUCTION = (RESET && (state == IDLE) && hit) ?
                        get_word(rd_block, PC[OFF_LSB +: OFF_BITS]) : NOP_INSTR;

   // MEM_ADDRESS doubles as the latched miss address for the whole refill
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state       <= IDLE;
         MEM_READ    <= 1'b0;
         MEM_ADDRESS <= '0;
         refill_q    <= '0;
      end else begin
         case (state)
            IDLE: if (!hit) begin
               MEM_ADDRESS <= PC[IDX_LSB +: MEM_ADDR_W];
               MEM_READ    <= 1'b1;
               state       <= FETCH;
            end
            FETCH: if (!MEM_BUSYWAIT) begin
               refill_q <= MEM_READINST;
               MEM_READ <= 1'b0;
               state    <= UPDATE;
            end
            UPDATE:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_instruction_cache.sv
// Randomised and directed fetch traffic against a cycle-level behavioural cache model.
module tb_instruction_cache;
   localparam int          LAT = 5;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic         CLK;
   logic         RESET = 1'b0;
   logic [31:0]  PC = 32'h0;
   logic [31:0]  INSTRUCTION;
   logic         BUSYWAIT;
   logic         MEM_READ;
   logic [5:0]   MEM_ADDRESS;
   logic [127:0] MEM_READINST = '0;
   logic         MEM_BUSYWAIT = 1'b1;

   instruction_cache dut (
      .CLK(CLK), .RESET(RESET), .PC(PC), .INSTRUCTION(INSTRUCTION),
      .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_ADDRESS(MEM_ADDRESS),
      .MEM_READINST(MEM_READINST), .MEM_BUSYWAIT(MEM_BUSYWAIT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Memory: busy for LAT cycles of MEM_READ, word value = byte address
   int mcnt = 0;
   always @(negedge CLK) begin
      if (MEM_READ === 1'b1) begin
         mcnt = mcnt + 1;
         MEM_BUSYWAIT = (mcnt != LAT);
         for (int w = 0; w < 4; w++)
            MEM_READINST[32*w +: 32] = {22'b0, MEM_ADDRESS, 4'b0} + 32'(4*w);
      end else begin
         mcnt = 0;
         MEM_BUSYWAIT = 1'b1;
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Directed literal expectations for the current cycle
   bit          lit_on = 0;
   logic [31:0] lit_instr = '0;
   bit          lit_aon = 0;
   logic [5:0]  lit_addr = '0;

   // Behavioural model: tag store plus a refill timeline (t = cycles into the miss)
   bit         m_valid [8];
   logic [2:0] m_tag   [8];
   int         t = 0;
   logic [5:0] r_addr = '0;

   always begin
      @(negedge CLK or negedge RESET);
      if (RESET !== 1'b1) begin
         #1;
         chk("rst_mem_read", 32'(MEM_READ), 32'd0);
         chk("rst_busywait", 32'(BUSYWAIT), 32'd0);
         chk("rst_instr", INSTRUCTION, NOP);
         chk("rst_mem_addr", 32'(MEM_ADDRESS), 32'd0);
         for (int i = 0; i < 8; i++) m_valid[i] = 0;
         t = 0;
      end else begin
         logic [2:0]  idx, tg;
         logic        e_bw, e_rd;
         logic [31:0] e_ins;
         idx = PC[6:4];
         tg  = PC[9:7];
         e_rd = 0;
         e_bw = 1;
         e_ins = NOP;
         if (t == 0) begin
            if (m_valid[idx] && m_tag[idx] == tg) begin
               e_bw = 0;
               e_ins = {22'b0, PC[9:2], 2'b0};
            end else begin
               r_addr = PC[9:4];
               t = 1;
            end
         end else if (t <= LAT) begin
            e_rd = 1;
            t = t + 1;
         end else begin
            m_valid[r_addr[2:0]] = 1;
            m_tag[r_addr[2:0]] = r_addr[5:3];
            t = 0;
         end
         chk("busywait", 32'(BUSYWAIT), 32'(e_bw));
         chk("instruction", INSTRUCTION, e_ins);
         chk("mem_read", 32'(MEM_READ), 32'(e_rd));
         if (e_rd) chk("mem_address", 32'(MEM_ADDRESS), 32'(r_addr));
         if (lit_on) begin
            chk("lit_instr", INSTRUCTION, lit_instr);
            chk("lit_busywait", 32'(BUSYWAIT), 32'd0);
            chk("model_pin_instr", e_ins, lit_instr);
         end
         if (lit_aon) begin
            chk("lit_mem_read", 32'(MEM_READ), 32'd1);
            chk("lit_mem_addr", 32'(MEM_ADDRESS), 32'(lit_addr));
            chk("model_pin_addr", {31'b0, e_rd} & 32'(r_addr == lit_addr), 32'd1);
         end
      end
   end

   task automatic cyc(input logic [31:0] pc, input bit lon = 0, input logic [31:0] lval = '0,
                      input bit aon = 0, input logic [5:0] aval = '0);
      @(posedge CLK); #1;
      PC = pc; lit_on = lon; lit_instr = lval; lit_aon = aon; lit_addr = aval;
   endtask

   task automatic refill(input logic [31:0] pc, input logic [5:0] blk);
      repeat (LAT) cyc(pc, 0, '0, 1, blk);
      cyc(pc);
   endtask

   initial begin
      logic [31:0] npc;
      int r;
      repeat (3) @(posedge CLK);
      // Cold miss on 0x000, release acts as the miss cycle
      @(posedge CLK); #1; RESET = 1'b1; PC = 32'h000;
      refill(32'h000, 6'h00);
      cyc(32'h000, 1, 32'h0);
      cyc(32'h004, 1, 32'h4);
      cyc(32'h008, 1, 32'h8);
      cyc(32'h00C, 1, 32'hC);
      // Ignored PC bits
      cyc(32'h400, 1, 32'h0);
      cyc(32'h001, 1, 32'h0);
      // Conflict eviction on index 0
      cyc(32'h080);
      refill(32'h080, 6'h08);
      cyc(32'h080, 1, 32'h80);
      cyc(32'h000);
      refill(32'h000, 6'h00);
      cyc(32'h000, 1, 32'h0);
      // PC change while stalled
      cyc(32'h010);
      refill(32'h024, 6'h01);
      cyc(32'h024);
      refill(32'h024, 6'h02);
      cyc(32'h024, 1, 32'h24);
      // Reset during the third FETCH cycle
      cyc(32'h030);
      cyc(32'h030);
      cyc(32'h030);
      @(posedge CLK); #2; RESET = 1'b0;
      repeat (2) @(posedge CLK);
      #1; RESET = 1'b1;
      refill(32'h030, 6'h03);
      cyc(32'h030, 1, 32'h30);
      cyc(32'h000);
      refill(32'h000, 6'h00);
      cyc(32'h000, 1, 32'h0);
      // Random traffic, mostly sequential with a narrow tag range to get hits
      for (int i = 0; i < 500; i++) begin
         r = $urandom_range(0, 9);
         if (r < 6) npc = PC + 32'd4;
         else begin
            npc = $urandom;
            if (r < 9) npc[9:7] = 3'($urandom_range(0, 1));
         end
         cyc(npc);
      end
      cyc(PC);
      @(posedge CLK); #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
